// File: rtl/retire_trace_buffer_if.sv
// retire_trace_buffer_if: snoop, trigger and trace-stream signals of the retirement trace buffer.
// Rev 1.0
`default_nettype none

interface retire_trace_buffer_if #(
  parameter int XLEN = 32,
  parameter int CH   = 4
);
  logic                 arm;
  logic                 retire_valid;
  logic [XLEN-1:0]      retire_pc;
  logic [CH*XLEN-1:0]   retire_ch;
  logic                 trig_en;
  logic [XLEN-1:0]      trig_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [CH*XLEN-1:0]   out_ch;
  logic                 out_last;
  logic [1:0]           state;
  logic [15:0]          dropped;

  modport master (
    output arm, retire_valid, retire_pc, retire_ch, trig_en, trig_pc, out_ready,
    input  out_valid, out_pc, out_ch, out_last, state, dropped
  );

  modport slave (
    input  arm, retire_valid, retire_pc, retire_ch, trig_en, trig_pc, out_ready,
    output out_valid, out_pc, out_ch, out_last, state, dropped
  );
endinterface

`default_nettype wire

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: PC-triggered circular capture of retired instructions, drained oldest-first.
// Rev 1.0
`default_nettype none

module retire_trace_buffer #(
  parameter int XLEN     = 32,
  parameter int CH       = 4,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  retire_trace_buffer_if.slave bus
);
  localparam int            AW        = $clog2(DEPTH);
  localparam int            EW        = XLEN * (CH + 1);
  localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fill_q, fill_d;
  logic [AW:0]          remaining_q, remaining_d;
  logic [AW-1:0]        post_q, post_d;
  logic [15:0]          dropped_q, dropped_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [XLEN-1:0]      out_pc_q, out_pc_d;
  logic [CH*XLEN-1:0]   out_ch_q, out_ch_d;
  logic [EW-1:0]        mem_q [DEPTH];

  logic                 w_store;
  logic                 w_enter_dump;
  logic                 w_trig;
  logic [EW-1:0]        w_rd_entry;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    remaining_d  = remaining_q;
    post_d       = post_q;
    dropped_d    = dropped_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_pc_d     = out_pc_q;
    out_ch_d     = out_ch_q;
    w_store      = 1'b0;
    w_enter_dump = 1'b0;
    w_trig       = bus.retire_valid & bus.trig_en & (bus.retire_pc == bus.trig_pc);
    w_rd_entry   = mem_q[rd_ptr_q];

    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d   = S_ARMED;
          wr_ptr_d  = '0;
          fill_d    = '0;
          dropped_d = '0;
        end
      end
      S_ARMED: begin
        if (bus.retire_valid) begin
          w_store = 1'b1;
          if (w_trig) begin
            post_d = POST_INIT;
            if (POST_CNT > 0) begin
              state_d = S_POST;
            end else begin
              state_d      = S_DUMP;
              w_enter_dump = 1'b1;
            end
          end
        end
      end
      S_POST: begin
        if (bus.retire_valid) begin
          w_store = 1'b1;
          post_d  = post_q - AW'(1);
          if (post_q == AW'(1)) begin
            state_d      = S_DUMP;
            w_enter_dump = 1'b1;
          end
        end
      end
      S_DUMP: begin
        if (bus.retire_valid && (dropped_q != 16'hFFFF)) begin
          dropped_d = dropped_q + 16'd1;
        end
        // A beat transfers and the next one loads on the same edge, so the stream has no bubbles.
        if (out_valid_q && bus.out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else if ((!out_valid_q || bus.out_ready) && (remaining_q != '0)) begin
          out_valid_d = 1'b1;
          out_pc_d    = w_rd_entry[XLEN-1:0];
          out_ch_d    = w_rd_entry[EW-1:XLEN];
          out_last_d  = (remaining_q == (AW + 1)'(1));
          rd_ptr_d    = rd_ptr_q + AW'(1);
          remaining_d = remaining_q - (AW + 1)'(1);
        end
      end
    endcase

    if (w_store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + (AW + 1)'(1);
    end
    // With a full buffer the low bits of fill are zero, so the oldest entry is the write pointer.
    if (w_enter_dump) begin
      rd_ptr_d    = wr_ptr_d - fill_d[AW-1:0];
      remaining_d = fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      post_q      <= '0;
      dropped_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pc_q    <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      post_q      <= post_d;
      dropped_q   <= dropped_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pc_q    <= out_pc_d;
      out_ch_q    <= out_ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      mem_q[wr_ptr_q] <= {bus.retire_ch, bus.retire_pc};
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.state     = state_q;
  assign bus.dropped   = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: scoreboard bench driving three buffer instances (POST_CNT 2, 8 and 0).
// Rev 1.0
`default_nettype none

module tb_retire_trace_buffer;
  localparam int XLEN = 32;
  localparam int CH   = 4;

  typedef struct {
    logic [XLEN-1:0]    pc;
    logic [CH*XLEN-1:0] ch;
    logic               last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic arm, retire_valid, trig_en, out_ready;
  logic [XLEN-1:0]    retire_pc, trig_pc;
  logic [CH*XLEN-1:0] retire_ch;

  logic               o_valid_a   [3];
  logic               o_last_a    [3];
  logic [XLEN-1:0]    o_pc_a      [3];
  logic [CH*XLEN-1:0] o_ch_a      [3];
  logic [1:0]         o_state_a   [3];
  logic [15:0]        o_dropped_a [3];

  int n_cmp  = 0;
  int n_fail = 0;
  int sel    = 0;

  int              m_phase, m_post, m_postcnt, m_drop;
  logic [XLEN-1:0] stored [$];
  beat_t           exp_q  [$];

  always #5 clk = ~clk;

  retire_trace_buffer_if #(.XLEN(XLEN), .CH(CH)) bus_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus_if[g].arm          = arm;
    assign bus_if[g].retire_valid = retire_valid;
    assign bus_if[g].retire_pc    = retire_pc;
    assign bus_if[g].retire_ch    = retire_ch;
    assign bus_if[g].trig_en      = trig_en;
    assign bus_if[g].trig_pc      = trig_pc;
    assign bus_if[g].out_ready    = out_ready;
    assign o_valid_a[g]   = bus_if[g].out_valid;
    assign o_last_a[g]    = bus_if[g].out_last;
    assign o_pc_a[g]      = bus_if[g].out_pc;
    assign o_ch_a[g]      = bus_if[g].out_ch;
    assign o_state_a[g]   = bus_if[g].state;
    assign o_dropped_a[g] = bus_if[g].dropped;

    retire_trace_buffer #(
      .XLEN(XLEN), .CH(CH), .DEPTH(16),
      .POST_CNT((g == 0) ? 2 : ((g == 1) ? 8 : 0))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if[g])
    );
  end

  function automatic logic [CH*XLEN-1:0] ch_of(input logic [XLEN-1:0] pc);
    return {pc ^ 32'hA5A5_5A5A, pc + 32'h0000_1111, ~pc, {pc[15:0], pc[31:16]}};
  endfunction

  task automatic enter_dump();
    int n = stored.size();
    int k = (n > 16) ? 16 : n;
    beat_t b;
    m_phase = 3;
    for (int i = n - k; i < n; i++) begin
      b.pc = stored[i]; b.ch = ch_of(stored[i]); b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic model_step(input logic a, input logic rv, input logic [XLEN-1:0] pc);
    if (m_phase == 0) begin
      if (a) begin m_phase = 1; stored.delete(); m_drop = 0; end
    end else if (rv) begin
      if (m_phase == 3) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        stored.push_back(pc);
        if (m_phase == 1) begin
          if (trig_en && pc == trig_pc) begin
            if (m_postcnt > 0) begin m_phase = 2; m_post = m_postcnt; end
            else enter_dump();
          end
        end else begin
          m_post--;
          if (m_post == 0) enter_dump();
        end
      end
    end
  endtask

  task automatic cyc(input logic a, input logic rv, input logic [XLEN-1:0] pc);
    @(negedge clk);
    arm = a; retire_valid = rv; retire_pc = pc; retire_ch = ch_of(pc);
    model_step(a, rv, pc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; arm = 1'b0; retire_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_phase = 0; m_drop = 0; stored.delete(); exp_q.delete();
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: stalled for 4 cycles then ready.
  task automatic drain(input int budget, input int mode, input int n_rv, input int max_beats);
    int popped = 0;
    logic held = 1'b0;
    logic rdy;
    logic [XLEN-1:0] hpc;
    logic [CH*XLEN-1:0] hch;
    beat_t e;
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 || (max_beats > 0 && popped >= max_beats)) break;
      @(negedge clk);
      arm = 1'b0; retire_valid = (c < n_rv); retire_pc = 32'hDEAD_0000 + c; retire_ch = ch_of(retire_pc);
      if (c < n_rv) model_step(1'b0, 1'b1, retire_pc);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((c % 4) == 0) || ((c % 4) == 3);
        default: rdy = (c >= 4);
      endcase
      out_ready = rdy;
      if (held) begin
        n_cmp++;
        if ({o_valid_a[sel], o_pc_a[sel], o_ch_a[sel]} !== {1'b1, hpc, hch}) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b pc=%h, required valid=1 pc=%h", o_valid_a[sel], o_pc_a[sel], hpc);
        end
      end
      held = 1'b0;
      if (o_valid_a[sel]) begin
        if (rdy) begin
          e = exp_q.pop_front();
          popped++;
          n_cmp++;
          if (o_pc_a[sel] !== e.pc) begin
            n_fail++; $display("FAIL beat_pc: got %h, required %h", o_pc_a[sel], e.pc);
          end
          n_cmp++;
          if (o_ch_a[sel] !== e.ch) begin
            n_fail++; $display("FAIL beat_ch: got %h, required %h", o_ch_a[sel], e.ch);
          end
          n_cmp++;
          if (o_last_a[sel] !== e.last) begin
            n_fail++; $display("FAIL beat_last: pc %h got last=%0b, required %0b", e.pc, o_last_a[sel], e.last);
          end
          if (e.last) m_phase = 0;
        end else begin
          held = 1'b1; hpc = o_pc_a[sel]; hch = o_ch_a[sel];
        end
      end
    end
    n_cmp++;
    if ((max_beats == 0) ? (exp_q.size() != 0) : (popped < max_beats)) begin
      n_fail++;
      $display("FAIL beat_timeout: %0d beats delivered, %0d still expected", popped, exp_q.size());
    end
    @(negedge clk);
    retire_valid = 1'b0; out_ready = 1'b0;
    if (max_beats == 0) begin
      n_cmp++;
      if ({o_valid_a[sel], o_state_a[sel]} !== 3'b0_00) begin
        n_fail++; $display("FAIL dump_end: got valid=%0b state=%0d, required valid=0 state=0", o_valid_a[sel], o_state_a[sel]);
      end
      n_cmp++;
      if (o_dropped_a[sel] !== 16'(m_drop)) begin
        n_fail++; $display("FAIL dropped: got %0d, required %0d", o_dropped_a[sel], m_drop);
      end
    end
  endtask

  task automatic check_state(input logic [1:0] want, input string tag);
    n_cmp++;
    if (o_state_a[sel] !== want) begin
      n_fail++; $display("FAIL state_%s: got %0d, required %0d", tag, o_state_a[sel], want);
    end
  endtask

  task automatic run_t2(input int mode, input int max_beats);
    do_reset();
    sel = 0; m_postcnt = 2; trig_en = 1'b1; trig_pc = 32'h08;
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h00);
    cyc(1'b0, 1'b1, 32'h04);
    check_state(2'd1, "armed");
    cyc(1'b0, 1'b1, 32'h08);
    cyc(1'b0, 1'b1, 32'h0C);
    check_state(2'd2, "post");
    cyc(1'b0, 1'b1, 32'h10);
    cyc(1'b0, 1'b0, 32'h0);
    check_state(2'd3, "dump");
    drain(100, mode, 0, max_beats);
  endtask

  task automatic test_reset();
    rst = 1'b0; arm = 1'b1; retire_valid = 1'b0; out_ready = 1'b0;
    trig_en = 1'b0; trig_pc = '0; retire_pc = '0; retire_ch = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({o_state_a[k], o_valid_a[k], o_last_a[k]} !== 4'b0) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got state=%0d valid=%0b last=%0b, required 0", k, o_state_a[k], o_valid_a[k], o_last_a[k]);
      end
      n_cmp++;
      if ({o_dropped_a[k], o_pc_a[k], o_ch_a[k]} !== '0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got dropped=%0d pc=%h, required 0", k, o_dropped_a[k], o_pc_a[k]);
      end
    end
    arm = 1'b0; rst = 1'b1;
    m_phase = 0; m_drop = 0;
  endtask

  task automatic test_no_wrap();
    run_t2(0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    sel = 1; m_postcnt = 8; trig_en = 1'b1; trig_pc = 32'(4 * 21);
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 32'(4 * i));
    cyc(1'b0, 1'b0, 32'h0);
    check_state(2'd3, "wrap_dump");
    drain(200, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_t2(1, 0);
  endtask

  task automatic test_edge_cases();
    do_reset();
    sel = 2; m_postcnt = 0; trig_en = 1'b1; trig_pc = 32'h100;
    cyc(1'b1, 1'b1, 32'h100);   // arm with a simultaneous (uncaptured) matching retirement
    cyc(1'b1, 1'b0, 32'h0);     // arm while ARMED: no effect
    check_state(2'd1, "arm_only");
    cyc(1'b0, 1'b0, 32'h0);
    check_state(2'd1, "rearm_ignored");
    cyc(1'b0, 1'b1, 32'h100);
    drain(100, 2, 3, 0);
  endtask

  task automatic test_reset_mid_dump();
    run_t2(0, 2);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_valid_a[sel], o_state_a[sel]} !== 3'b0_00) begin
      n_fail++; $display("FAIL abort: got valid=%0b state=%0d, required valid=0 state=0", o_valid_a[sel], o_state_a[sel]);
    end
    rst = 1'b1;
    m_phase = 0; m_drop = 0; stored.delete(); exp_q.delete();
    trig_pc = 32'h1008;
    cyc(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h1000 + 32'(4 * i));
    cyc(1'b0, 1'b0, 32'h0);
    check_state(2'd3, "rearm_dump");
    drain(100, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_no_wrap();
    test_wrap();
    test_backpressure();
    test_edge_cases();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
